main_mem_burst: RTL and testbench

- Clocked, parametrised successor to the main memory behind the L1 cache model.
- Keeps the fully interlocked four-phase request/ACK handshake.
- Adds a clock, synchronous active-low reset, configurable width/depth/latency, byte enables, split read/write data buses and wrap-around cache-line bursts.
- Sits between the L1 cache fill/writeback logic and the backing array. Default geometry is 64KB of 32-bit words.

---
 rtl/main_mem_pkg.sv | 26 ++
 rtl/main_mem_burst_if.sv | 27 ++
 rtl/main_mem_burst_mem_array.sv | 45 ++++
 rtl/main_mem_burst.sv | 147 ++++++++++++++
 tb/tb_main_mem_burst.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and helpers for the main_mem_burst memory slice.
//   - mem_state_e : controller FSM states
//   - woff()      : byte-offset bit count of a data word
//   - wrap_index(): critical-word-first word index, wrapping inside an aligned line
//   - MemDefault* : default 64KB geometry
package main_mem_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StAckh, StGap} mem_state_e;

  localparam int unsigned MemDefaultBytes = 65536;
  localparam int unsigned MemDefaultAddrW = $clog2(MemDefaultBytes);
  localparam int unsigned MemDefaultDataW = 32;

  function automatic int unsigned woff(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Keep the line bits of base, advance only the in-line offset modulo burst_len.
  function automatic logic [31:0] wrap_index(input logic [31:0] base, input logic [31:0] beat,
                                             input int unsigned burst_len);
    logic [31:0] mask;
    mask = burst_len - 1;
    return (base & ~mask) | ((base + beat) & mask);
  endfunction

endpackage

// File: rtl/main_mem_burst_if.sv
// main_mem_burst_if: four-phase request/ACK memory bus.
//   master drives MEM_Request, MEM_WE, MEM_Burst, MEM_Address, MEM_WData, MEM_BE
//   slave drives MEM_RData, MEM_ACK, MEM_Busy, MEM_Err
interface main_mem_burst_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic                MEM_Request;
  logic                MEM_WE;
  logic                MEM_Burst;
  logic [31:0]         MEM_Address;
  logic [DATA_W-1:0]   MEM_WData;
  logic [DATA_W/8-1:0] MEM_BE;
  logic [DATA_W-1:0]   MEM_RData;
  logic                MEM_ACK;
  logic                MEM_Busy;
  logic                MEM_Err;

  modport master (
    output MEM_Request, MEM_WE, MEM_Burst, MEM_Address, MEM_WData, MEM_BE,
    input  MEM_RData, MEM_ACK, MEM_Busy, MEM_Err
  );

  modport slave (
    input  MEM_Request, MEM_WE, MEM_Burst, MEM_Address, MEM_WData, MEM_BE,
    output MEM_RData, MEM_ACK, MEM_Busy, MEM_Err
  );
endinterface

// File: rtl/main_mem_burst_mem_array.sv
// mem_array: single-port synchronous RAM with per-byte write enables.
//   clk_i, rst_ni : clock, synchronous active-low reset (read register only)
//   en_i, we_i    : access enable, 1 = write / 0 = read
//   be_i          : byte enables for writes
//   addr_i        : word index
//   wdata_i       : write data
//   rdata_o       : registered read data, held until the next read
// Array contents are never reset.
module mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16384,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [IDX_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_mem_burst.sv
// main_mem_burst: clocked main memory with four-phase request/ACK handshake,
// byte enables and wrap-around cache-line bursts.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : main_mem_burst_if slave port (request/WE/burst/address/wdata/BE in,
//           rdata/ACK/busy/err out)
// Optional feature macro MEM_ADDR_CHECK_EN: address bits above ADDR_W must be zero,
// otherwise the transaction completes with no write, zero read data and MEM_Err
// raised with each ACK. Without it MEM_Err is 0 and high address bits alias.
module main_mem_burst
  import main_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = MemDefaultDataW,
  parameter int unsigned ADDR_W    = MemDefaultAddrW,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned WRITE_LAT = 2,
  parameter int unsigned BEAT_LAT  = 1
) (
  input logic             clk,
  input logic             rst_n,
  main_mem_burst_if.slave bus
);
  localparam int unsigned WOFF   = woff(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - WOFF;
  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned LAT_M0 = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned LAT_MX = (LAT_M0 > BEAT_LAT) ? LAT_M0 : BEAT_LAT;
  localparam int unsigned LAT_W  = $clog2(LAT_MX) + 1;

  mem_state_e        state_q;
  logic              we_q, burst_q, ack_q, busy_q, err_q;
  logic [IDX_W-1:0]  base_q;
  logic [LAT_W-1:0]  lat_q;
  logic [BEAT_W-1:0] beat_q;

  logic              ack_edge, last_beat, addr_err, ram_en;
  logic [IDX_W-1:0]  beat_idx;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  // Word offset bits and (without the check) high bits are intentionally ignored.
  assign unused_addr = ^bus.MEM_Address;

  assign ack_edge  = (state_q == StWait) && (lat_q == '0);
  assign last_beat = !burst_q || (beat_q == BEAT_W'(BURST_LEN - 1));
  assign beat_idx  = IDX_W'(wrap_index(32'(base_q), 32'(beat_q), BURST_LEN));
  // Gating with rst_n keeps a write from committing on a reset edge.
  assign ram_en    = rst_n && ack_edge && !err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.MEM_Request && !ack_q) begin
            we_q    <= bus.MEM_WE;
            burst_q <= bus.MEM_Burst;
            base_q  <= bus.MEM_Address[ADDR_W-1:WOFF];
            lat_q   <= bus.MEM_WE ? LAT_W'(WRITE_LAT - 1) : LAT_W'(READ_LAT - 1);
            err_q   <= addr_err;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (lat_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= StAckh;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        StAckh: begin
          if (!bus.MEM_Request) begin
            ack_q <= 1'b0;
            if (last_beat) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b0;
              state_q <= StIdle;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (bus.MEM_Request) begin
            lat_q   <= LAT_W'(BEAT_LAT - 1);
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (ram_en),
    .we_i   (we_q),
    .be_i   (bus.MEM_BE),
    .addr_i (beat_idx),
    .wdata_i(bus.MEM_WData),
    .rdata_o(ram_rdata)
  );

`ifdef MEM_ADDR_CHECK_EN
  logic rdata_zero_q;

  assign addr_err = |bus.MEM_Address[31:ADDR_W];

  // An out-of-range read presents zero until the next read ACK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_zero_q <= 1'b0;
    end else if (ack_edge && !we_q) begin
      rdata_zero_q <= err_q;
    end
  end

  assign bus.MEM_RData = rdata_zero_q ? '0 : ram_rdata;
  assign bus.MEM_Err   = ack_q & err_q;
`else
  assign addr_err      = 1'b0;
  assign bus.MEM_RData = ram_rdata;
  assign bus.MEM_Err   = 1'b0;
`endif

  assign bus.MEM_ACK  = ack_q;
  assign bus.MEM_Busy = busy_q;
endmodule

// File: tb/tb_main_mem_burst.sv
// tb_main_mem_burst: directed, table-driven bench for main_mem_burst (default geometry).
module tb_main_mem_burst;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  main_mem_burst_if #(.DATA_W(32)) bus ();

  main_mem_burst dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One handshake beat: raise request, wait (bounded) for ACK, drop request.
  task automatic run_beat(input int exp_lat, input logic exp_err, input string tag,
                          output logic [31:0] rd);
    int cyc;
    @(negedge clk);
    bus.MEM_Request = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (!bus.MEM_ACK && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " ack latency"}, cyc, exp_lat);
    check({tag, " err"}, 32'(bus.MEM_Err), 32'(exp_err));
    rd = bus.MEM_RData;
    @(negedge clk);
    bus.MEM_Request = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ack drop"}, 32'(bus.MEM_ACK), 32'h0);
  endtask

  // Full transaction; after the first beat WE and address are scrambled since they
  // must be ignored from then on.
  task automatic xact(input logic we, input logic burst, input logic [31:0] addr,
                      input logic [127:0] wd, input logic [3:0] be, input logic exp_err,
                      input string tag, output logic [127:0] rd);
    int n;
    logic [31:0] r;
    n = burst ? 4 : 1;
    rd = '0;
    bus.MEM_WE      = we;
    bus.MEM_Burst   = burst;
    bus.MEM_Address = addr;
    bus.MEM_BE      = be;
    for (int b = 0; b < n; b++) begin
      bus.MEM_WData = wd[32*b +: 32];
      run_beat((b == 0) ? (we ? 2 : 4) : 1, exp_err, $sformatf("%s b%0d", tag, b), r);
      rd[32*b +: 32] = r;
      check($sformatf("%s b%0d busy", tag, b), 32'(bus.MEM_Busy), (b == n - 1) ? 32'h0 : 32'h1);
      bus.MEM_WE      = ~we;
      bus.MEM_Address = 32'hFFFF_FFFC;
    end
  endtask

  logic [127:0] rd;
  int           cyc;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.MEM_Request = 1'b0;
    bus.MEM_WE      = 1'b0;
    bus.MEM_Burst   = 1'b0;
    bus.MEM_Address = '0;
    bus.MEM_WData   = '0;
    bus.MEM_BE      = '0;

    // {we, addr, wdata, be, check rdata, expected rdata, expected err}
    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0100, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0100, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,        4'hF, 1'b1, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0108, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0108, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0108, 32'h0,        4'hF, 1'b1, 32'h01020304, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0044, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0047, 32'h0,        4'hF, 1'b1, 32'h12345678, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0004, 32'hCAFE0004, 4'hF, 1'b0, 32'h0, 1'b0};
`ifdef MEM_ADDR_CHECK_EN
    vecs[11] = '{1'b1, 32'h0001_0004, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 1'b1, 32'hCAFE0004, 1'b0};
    vecs[13] = '{1'b0, 32'h0001_0004, 32'h0,        4'hF, 1'b1, 32'h0, 1'b1};
`else
    vecs[11] = '{1'b1, 32'h0001_0004, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 1'b1, 32'h55AA55AA, 1'b0};
    vecs[13] = '{1'b0, 32'h0001_0004, 32'h0,        4'hF, 1'b1, 32'h55AA55AA, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 32'(bus.MEM_ACK), 32'h0);
    check("reset busy", 32'(bus.MEM_Busy), 32'h0);
    check("reset err", 32'(bus.MEM_Err), 32'h0);
    check("reset rdata", bus.MEM_RData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      xact(vecs[i].we, 1'b0, vecs[i].addr, {96'h0, vecs[i].wd}, vecs[i].be, vecs[i].err,
           $sformatf("vec%0d", i), rd);
      if (vecs[i].chk) check($sformatf("vec%0d rdata", i), rd[31:0], vecs[i].exp);
    end

    // Burst write from 0x10 fills 0x10..0x1C with their own addresses.
    xact(1'b1, 1'b1, 32'h10, {32'h1C, 32'h18, 32'h14, 32'h10}, 4'hF, 1'b0, "bw10", rd);
    xact(1'b0, 1'b1, 32'h18, 128'h0, 4'hF, 1'b0, "br18", rd);
    check("br18 beat0", rd[31:0], 32'h18);
    check("br18 beat1", rd[63:32], 32'h1C);
    check("br18 beat2", rd[95:64], 32'h10);
    check("br18 beat3", rd[127:96], 32'h14);

    // Wrapping burst write starting mid-line at 0x2C.
    xact(1'b1, 1'b1, 32'h2C, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0, "bw2c", rd);
    xact(1'b0, 1'b1, 32'h20, 128'h0, 4'hF, 1'b0, "br20", rd);
    check("br20 beat0", rd[31:0], 32'hA1);
    check("br20 beat1", rd[63:32], 32'hA2);
    check("br20 beat2", rd[95:64], 32'hA3);
    check("br20 beat3", rd[127:96], 32'hA0);

    // Request dropped before ACK: ACK still comes after READ_LAT, then clears.
    bus.MEM_WE      = 1'b0;
    bus.MEM_Burst   = 1'b0;
    bus.MEM_Address = 32'h0000_0100;
    @(negedge clk);
    bus.MEM_Request = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.MEM_Request = 1'b0;
    cyc = 1;
    @(posedge clk);
    #1;
    while (!bus.MEM_ACK && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("early drop latency", cyc, 32'd4);
    check("early drop rdata", bus.MEM_RData, 32'h11BB33DD);
    @(posedge clk);
    #1;
    check("early drop ack clear", 32'(bus.MEM_ACK), 32'h0);
    check("early drop busy", 32'(bus.MEM_Busy), 32'h0);

    // Reset during WAIT of a write to 0x0200 must not commit it.
    xact(1'b1, 1'b0, 32'h200, {96'h0, 32'h77777777}, 4'hF, 1'b0, "w200", rd);
    bus.MEM_WE      = 1'b1;
    bus.MEM_Burst   = 1'b0;
    bus.MEM_Address = 32'h200;
    bus.MEM_WData   = 32'h99999999;
    @(negedge clk);
    bus.MEM_Request = 1'b1;
    @(posedge clk);
    #1;
    check("rst-mid busy before", 32'(bus.MEM_Busy), 32'h1);
    @(negedge clk);
    rst_n           = 1'b0;
    bus.MEM_Request = 1'b0;
    @(posedge clk);
    #1;
    check("rst-mid ack", 32'(bus.MEM_ACK), 32'h0);
    check("rst-mid busy", 32'(bus.MEM_Busy), 32'h0);
    check("rst-mid rdata", bus.MEM_RData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst-mid no late ack", 32'(bus.MEM_ACK), 32'h0);
    xact(1'b0, 1'b0, 32'h200, 128'h0, 4'hF, 1'b0, "r200", rd);
    check("rst-mid word kept", rd[31:0], 32'h77777777);

    // Every 4KB block: line at its start and last word, tagged (block + 100).
    for (int blk = 0; blk < 16; blk++) begin
      xact(1'b1, 1'b1, 32'(blk) << 12, {4{32'(blk + 100)}}, 4'hF, 1'b0,
           $sformatf("fill%0d", blk), rd);
      xact(1'b1, 1'b0, (32'(blk) << 12) + 32'hFFC, {96'h0, 32'(blk + 100)}, 4'hF, 1'b0,
           $sformatf("fillend%0d", blk), rd);
    end
    for (int blk = 0; blk < 16; blk++) begin
      xact(1'b0, 1'b0, (32'(blk) << 12) + 32'h4, 128'h0, 4'hF, 1'b0,
           $sformatf("rdb%0d", blk), rd);
      check($sformatf("blk%0d start", blk), rd[31:0], 32'(blk + 100));
      xact(1'b0, 1'b0, (32'(blk) << 12) + 32'hFFC, 128'h0, 4'hF, 1'b0,
           $sformatf("rde%0d", blk), rd);
      check($sformatf("blk%0d end", blk), rd[31:0], 32'(blk + 100));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
